// File: rtl/packet_deframer_crc.sv
// Optical-link receive deframer: hunts for the sync word, shifts in one packet,
// checks CRC-16 over address+data and keeps saturating link-diagnostic counters.
module packet_deframer_crc #(
    parameter logic [7:0]  SYNC_WORD = 8'hA5,
    parameter int unsigned PKT_LEN   = 71,
    parameter logic [15:0] CRC_POLY  = 16'h1021,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF,
    parameter logic [15:0] TIMEOUT   = 16'd5000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_en,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic [PKT_LEN-1:0] seventy_one_bit_packet,
    output logic               crc_done,
    output logic               crc_good,
    output logic [1:0]         state,
    output logic [15:0]        good_count,
    output logic [15:0]        bad_count,
    output logic [7:0]         abort_count
);

    localparam int unsigned CRC_W    = 16;
    localparam int unsigned SYNC_W   = 8;
    localparam int unsigned CNT_W    = $clog2(PKT_LEN + 1);
    localparam int unsigned CRC_BITS = PKT_LEN - CRC_W;

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    // Reset asserts asynchronously and releases on a clock edge.
    logic r_rst_meta;
    logic r_rst_sync;
    logic w_rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst_n = r_rst_sync;

    state_t             r_state,     w_state_nxt;
    logic [SYNC_W-1:0]  r_sync_sr,   w_sync_nxt;
    logic [PKT_LEN-1:0] r_pkt_sr,    w_pkt_nxt;
    logic [CNT_W-1:0]   r_bit_cnt,   w_bit_cnt_nxt;
    logic [CRC_W-1:0]   r_crc,       w_crc_nxt;
    logic [15:0]        r_tmo_cnt,   w_tmo_nxt;
    logic [PKT_LEN-1:0] r_pkt_out,   w_pkt_out_nxt;
    logic               r_crc_good,  w_crc_good_nxt;
    logic               r_crc_done,  w_crc_done_nxt;
    logic [15:0]        r_good_cnt,  w_good_nxt;
    logic [15:0]        r_bad_cnt,   w_bad_nxt;
    logic [7:0]         r_abort_cnt, w_abort_nxt;

    logic [SYNC_W-1:0]  w_sync_upd;
    logic [CRC_W-1:0]   w_crc_step;
    logic               w_abort;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= S_HUNT;
            r_sync_sr   <= '0;
            r_pkt_sr    <= '0;
            r_bit_cnt   <= '0;
            r_crc       <= CRC_INIT;
            r_tmo_cnt   <= '0;
            r_pkt_out   <= '0;
            r_crc_good  <= 1'b0;
            r_crc_done  <= 1'b0;
            r_good_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_abort_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sync_sr   <= w_sync_nxt;
            r_pkt_sr    <= w_pkt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_crc       <= w_crc_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
            r_pkt_out   <= w_pkt_out_nxt;
            r_crc_good  <= w_crc_good_nxt;
            r_crc_done  <= w_crc_done_nxt;
            r_good_cnt  <= w_good_nxt;
            r_bad_cnt   <= w_bad_nxt;
            r_abort_cnt <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sync_nxt     = r_sync_sr;
        w_pkt_nxt      = r_pkt_sr;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_crc_nxt      = r_crc;
        w_tmo_nxt      = r_tmo_cnt;
        w_pkt_out_nxt  = r_pkt_out;
        w_crc_good_nxt = r_crc_good;
        w_crc_done_nxt = 1'b0;
        w_good_nxt     = r_good_cnt;
        w_bad_nxt      = r_bad_cnt;
        w_abort_nxt    = r_abort_cnt;
        w_abort        = 1'b0;

        w_sync_upd = {r_sync_sr[SYNC_W-2:0], bit_in};
        w_crc_step = {r_crc[CRC_W-2:0], 1'b0} ^ ((r_crc[CRC_W-1] ^ bit_in) ? CRC_POLY : '0);

        case (r_state)
            S_HUNT: begin
                if (rx_en && bit_valid) begin
                    w_sync_nxt = w_sync_upd;
                    if (w_sync_upd == SYNC_WORD) begin
                        w_state_nxt   = S_RECV;
                        w_bit_cnt_nxt = '0;
                        w_crc_nxt     = CRC_INIT;
                        w_tmo_nxt     = '0;
                    end
                end
            end

            S_RECV: begin
                if (!rx_en) begin
                    w_abort = 1'b1;
                end else if (bit_valid) begin
                    w_pkt_nxt     = {r_pkt_sr[PKT_LEN-2:0], bit_in};
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    w_tmo_nxt     = '0;
                    // Only address+data bits feed the CRC; the trailing CRC field does not.
                    if (r_bit_cnt < CNT_W'(CRC_BITS)) begin
                        w_crc_nxt = w_crc_step;
                    end
                    if (r_bit_cnt == CNT_W'(PKT_LEN - 1)) begin
                        w_state_nxt = S_CHECK;
                    end
                end else if (r_tmo_cnt == TIMEOUT - 16'd1) begin
                    w_abort = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + 16'd1;
                end
            end

            S_CHECK: begin
                w_pkt_out_nxt  = r_pkt_sr;
                w_crc_good_nxt = (r_crc == r_pkt_sr[CRC_W-1:0]);
                w_crc_done_nxt = 1'b1;
                w_state_nxt    = S_HUNT;
                w_sync_nxt     = '0;
                if (r_crc == r_pkt_sr[CRC_W-1:0]) begin
                    if (r_good_cnt != '1) begin
                        w_good_nxt = r_good_cnt + 16'd1;
                    end
                end else if (r_bad_cnt != '1) begin
                    w_bad_nxt = r_bad_cnt + 16'd1;
                end
            end

            default: begin
                w_state_nxt = S_HUNT;
            end
        endcase

        if (w_abort) begin
            w_state_nxt = S_HUNT;
            if (r_abort_cnt != '1) begin
                w_abort_nxt = r_abort_cnt + 8'd1;
            end
        end
    end

    assign seventy_one_bit_packet = r_pkt_out;
    assign crc_done               = r_crc_done;
    assign crc_good               = r_crc_good;
    assign state                  = r_state;
    assign good_count             = r_good_cnt;
    assign bad_count              = r_bad_cnt;
    assign abort_count            = r_abort_cnt;

endmodule

// File: tb/tb_packet_deframer_crc.sv
// Directed self-checking bench for packet_deframer_crc: good/bad CRC, timeout,
// false sync, back-to-back, async reset, enable drop and counter saturation.
module tb_packet_deframer_crc;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_en;
    logic        bit_in;
    logic        bit_valid;
    logic [70:0] seventy_one_bit_packet;
    logic        crc_done;
    logic        crc_good;
    logic [1:0]  state;
    logic [15:0] good_count;
    logic [15:0] bad_count;
    logic [7:0]  abort_count;

    int errors = 0;
    int checks = 0;
    int done_pulses = 0;
    logic last_good = 1'b0;

    logic [54:0] msg;
    logic [70:0] p1;
    logic [70:0] p2;

    packet_deframer_crc dut (
        .clk                    (clk),
        .reset                  (reset),
        .rx_en                  (rx_en),
        .bit_in                 (bit_in),
        .bit_valid              (bit_valid),
        .seventy_one_bit_packet (seventy_one_bit_packet),
        .crc_done               (crc_done),
        .crc_good               (crc_good),
        .state                  (state),
        .good_count             (good_count),
        .bad_count              (bad_count),
        .abort_count            (abort_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (crc_done) begin
            done_pulses <= done_pulses + 1;
            last_good   <= crc_good;
        end
    end

    task automatic chk(input string tag, input logic [70:0] act, input logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // CRC-16 reference: init FFFF, poly 1021, message MSB first.
    function automatic logic [15:0] crc_model(input logic [54:0] m);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 54; i >= 0; i--) begin
            fb = c[15] ^ m[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_in    = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_bits(input logic [70:0] p, input int n);
        for (int i = 0; i < n; i++) send_bit(p[70-i]);
    endtask

    task automatic send_pkt(input logic [70:0] p);
        send_byte(8'hA5);
        send_bits(p, 71);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b0;
        rx_en     = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        msg = {19'h00005, 36'h123456789};
        p1  = {msg, crc_model(msg)};
        p2  = p1 ^ (71'd1 << 30);

        #2;
        chk("rst_state", 71'(state), 71'd0);
        chk("rst_done", 71'(crc_done), 71'd0);
        chk("rst_counts", 71'({good_count, bad_count, abort_count}), 71'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_cyc(4);

        // T1 good packet with exact latency
        send_byte(8'hA5);
        send_bits(p1, 71);
        chk("t1_state_check", 71'(state), 71'd2);
        chk("t1_done_early", 71'(crc_done), 71'd0);
        @(negedge clk);
        chk("t1_done", 71'(crc_done), 71'd1);
        chk("t1_good", 71'(crc_good), 71'd1);
        chk("t1_packet", seventy_one_bit_packet, p1);
        chk("t1_good_count", 71'(good_count), 71'd1);
        chk("t1_state_hunt", 71'(state), 71'd0);
        @(negedge clk);
        chk("t1_done_fall", 71'(crc_done), 71'd0);
        wait_cyc(1);
        chk("t1_pulses", 71'(done_pulses), 71'd1);

        // T2 bad CRC
        send_pkt(p2);
        wait_cyc(3);
        chk("t2_good", 71'(crc_good), 71'd0);
        chk("t2_bad_count", 71'(bad_count), 71'd1);
        chk("t2_good_count", 71'(good_count), 71'd1);
        chk("t2_packet", seventy_one_bit_packet, p2);
        chk("t2_pulses", 71'(done_pulses), 71'd2);

        // T3 timeout then recovery
        send_byte(8'hA5);
        send_bits(p1, 40);
        wait_cyc(4990);
        chk("t3_still_recv", 71'(state), 71'd1);
        wait_cyc(20);
        chk("t3_state", 71'(state), 71'd0);
        chk("t3_abort", 71'(abort_count), 71'd1);
        chk("t3_no_done", 71'(done_pulses), 71'd2);
        chk("t3_pkt_held", seventy_one_bit_packet, p2);
        send_pkt(p1);
        wait_cyc(3);
        chk("t3_good_count", 71'(good_count), 71'd2);
        chk("t3_crc_good", 71'(crc_good), 71'd1);
        chk("t3_pulses", 71'(done_pulses), 71'd3);

        // T4 false sync and back-to-back
        send_byte(8'hA4);
        send_byte(8'h5A);
        send_pkt(p1);
        send_pkt(p1);
        wait_cyc(3);
        chk("t4_pulses", 71'(done_pulses), 71'd5);
        chk("t4_good_count", 71'(good_count), 71'd4);
        chk("t4_bad_count", 71'(bad_count), 71'd1);
        chk("t4_last_good", 71'(last_good), 71'd1);

        // T5 async reset mid-packet
        send_byte(8'hA5);
        send_bits(p1, 35);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t5_state", 71'(state), 71'd0);
        chk("t5_counts", 71'({good_count, bad_count, abort_count}), 71'd0);
        chk("t5_packet", seventy_one_bit_packet, 71'd0);
        chk("t5_crc_good", 71'(crc_good), 71'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_cyc(4);
        send_pkt(p1);
        wait_cyc(3);
        chk("t5_good_count", 71'(good_count), 71'd1);
        chk("t5_packet_after", seventy_one_bit_packet, p1);

        // T6 enable drop at bit 60
        send_byte(8'hA5);
        send_bits(p1, 59);
        @(negedge clk);
        rx_en = 1'b0;
        @(negedge clk);
        rx_en = 1'b1;
        wait_cyc(2);
        chk("t6_abort", 71'(abort_count), 71'd1);
        chk("t6_state", 71'(state), 71'd0);

        // sync register frozen while disabled in HUNT
        rx_en = 1'b0;
        send_byte(8'hA5);
        chk("t6_frozen_state", 71'(state), 71'd0);
        rx_en = 1'b1;
        wait_cyc(2);
        chk("t6_frozen_abort", 71'(abort_count), 71'd1);

        // abort counter saturation
        for (int k = 0; k < 253; k++) begin
            send_byte(8'hA5);
            @(negedge clk);
            rx_en = 1'b0;
            @(negedge clk);
            rx_en = 1'b1;
        end
        wait_cyc(2);
        chk("t6_abort_fe", 71'(abort_count), 71'hFE);
        for (int k = 0; k < 5; k++) begin
            send_byte(8'hA5);
            @(negedge clk);
            rx_en = 1'b0;
            @(negedge clk);
            rx_en = 1'b1;
        end
        wait_cyc(2);
        chk("t6_abort_sat", 71'(abort_count), 71'hFF);

        // bad counter saturation from a preloaded value
        @(negedge clk);
        force dut.r_bad_cnt = 16'hFFFD;
        #1;
        release dut.r_bad_cnt;
        send_pkt(p2);
        send_pkt(p2);
        wait_cyc(3);
        chk("t6_bad_ffff", 71'(bad_count), 71'hFFFF);
        send_pkt(p2);
        wait_cyc(3);
        chk("t6_bad_sat", 71'(bad_count), 71'hFFFF);
        chk("t6_bad_verdict", 71'(crc_good), 71'd0);
        chk("t6_good_kept", 71'(good_count), 71'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
